// File: rtl/generic_bus_arbiter.sv
// Round-robin, non-preemptive N-master to 1-slave arbiter for the generic bus.
// Define GENERIC_BUS_ARB_TIMEOUT_EN to add a watchdog that aborts hung slave transactions.
module generic_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int GRANT_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int BE_W          = DATA_W / 8
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic [NUM_MASTERS-1:0]        m_ren,
  input  logic [NUM_MASTERS-1:0]        m_wen,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*BE_W-1:0]   m_byte_en,
  output logic [NUM_MASTERS-1:0]        m_busy,
  output logic [NUM_MASTERS-1:0]        m_error,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_ren,
  output logic                          s_wen,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [BE_W-1:0]               s_byte_en,
  input  logic                          s_busy,
  input  logic                          s_error,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic                          grant_valid,
  output logic [GRANT_W-1:0]            grant_id,
  output logic                          timeout
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  if (NUM_MASTERS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("generic_bus_arbiter: NUM_MASTERS and TIMEOUT_CYCLES must be >= 1");
  end

  logic [0:0]             state_q, state_d;
  logic [GRANT_W-1:0]     grant_q, grant_d;
  logic [GRANT_W-1:0]     last_q, last_d;
  logic [NUM_MASTERS-1:0] req;
  logic [GRANT_W-1:0]     winner;
  logic                   tmo;

  assign req = m_ren | m_wen;

  // Rotating priority: scan upward from the master after the last one served.
  always_comb begin
    logic found;
    int   idx;
    found  = 1'b0;
    winner = last_q;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = GRANT_W'(idx);
      end
    end
  end

`ifdef GENERIC_BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tmo = (state_q == BUSY) && s_busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)  cnt_d = '0;
    else if (s_busy)      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    s_ren       = 1'b0;
    s_wen       = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_byte_en   = '0;
    m_busy      = '1;
    m_error     = '0;
    m_rdata     = '0;
    grant_valid = (state_q == BUSY);
    grant_id    = grant_q;
    timeout     = tmo;
    if (state_q == BUSY) begin
      // A watchdog abort withdraws the request and completes the master with an error.
      s_ren            = m_ren[grant_q] & ~tmo;
      s_wen            = m_wen[grant_q] & ~tmo;
      s_addr           = m_addr[int'(grant_q)*ADDR_W +: ADDR_W];
      s_wdata          = m_wdata[int'(grant_q)*DATA_W +: DATA_W];
      s_byte_en        = m_byte_en[int'(grant_q)*BE_W +: BE_W];
      m_busy[grant_q]  = s_busy & ~tmo;
      m_error[grant_q] = s_error | tmo;
      m_rdata          = tmo ? '0 : s_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = winner;
          state_d = BUSY;
        end
      end
      default: begin
        // Completion, request withdrawal and watchdog abort all release the bus.
        if (!s_busy || !req[grant_q] || tmo) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GRANT_W'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_generic_bus_arbiter.sv
// Bench for generic_bus_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_generic_bus_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 8;
`ifdef GENERIC_BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              nRST;
  logic [NM-1:0]     m_ren, m_wen;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM*BW-1:0]  m_byte_en;
  logic [NM-1:0]     m_busy, m_error;
  logic [DW-1:0]     m_rdata;
  logic              s_ren, s_wen;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [BW-1:0]     s_byte_en;
  logic              s_busy, s_error;
  logic [DW-1:0]     s_rdata;
  logic              grant_valid;
  logic [1:0]        grant_id;
  logic              timeout;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit md_busy;
  int md_owner, md_last, md_gid, md_cnt;

  generic_bus_arbiter #(
    .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_byte_en(m_byte_en),
    .m_busy(m_busy), .m_error(m_error), .m_rdata(m_rdata),
    .s_ren(s_ren), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata), .s_byte_en(s_byte_en),
    .s_busy(s_busy), .s_error(s_error), .s_rdata(s_rdata),
    .grant_valid(grant_valid), .grant_id(grant_id), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1);
  end

  task automatic zero_inputs;
    m_ren = '0; m_wen = '0; m_addr = '0; m_wdata = '0; m_byte_en = '0;
    s_busy = 1'b0; s_error = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset;
    @(negedge CLK);
    nRST = 1'b0;
    zero_inputs();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    md_busy = 1'b0; md_last = NM - 1; md_gid = 0; md_cnt = 0; md_owner = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    #1;
    total++;
    if ({m_busy, m_error, s_ren, s_wen, grant_valid, timeout, grant_id, m_rdata} !==
        {4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0}) begin
      bad++;
      $display("FAIL reset_values got=%h exp=%h",
               {m_busy, m_error, s_ren, s_wen, grant_valid, timeout, grant_id, m_rdata},
               {4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0});
    end
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    #1;
    total++;
    if ({grant_valid, s_ren, s_wen, m_busy} !== {1'b0, 1'b0, 1'b0, 4'hF}) begin
      bad++;
      $display("FAIL idle_after_reset got=%h exp=%h", {grant_valid, s_ren, s_wen, m_busy}, {1'b0, 1'b0, 1'b0, 4'hF});
    end
  endtask

  task automatic test_single_read;
    do_reset();
    m_ren[0] = 1'b1;
    m_addr[0 +: AW] = 32'h8000_0000;
    s_busy = 1'b1;
    #1;
    total++;
    if (grant_valid !== 1'b0) begin
      bad++; $display("FAIL read_arb_latency got=%b exp=0", grant_valid);
    end
    for (int c = 1; c <= 2; c++) begin
      @(negedge CLK); #1;
      total++;
      if ({grant_valid, grant_id, s_ren, s_wen, s_addr, m_busy} !== {1'b1, 2'd0, 1'b1, 1'b0, 32'h8000_0000, 4'hF}) begin
        bad++;
        $display("FAIL read_busy_c%0d got=%h exp=%h", c, {grant_valid, grant_id, s_ren, s_wen, s_addr, m_busy},
                 {1'b1, 2'd0, 1'b1, 1'b0, 32'h8000_0000, 4'hF});
      end
    end
    @(negedge CLK);
    s_busy = 1'b0;
    s_rdata = 32'hDEAD_BEEF;
    #1;
    total++;
    if ({m_busy, m_error, m_rdata} !== {4'hE, 4'h0, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL read_complete got=%h exp=%h", {m_busy, m_error, m_rdata}, {4'hE, 4'h0, 32'hDEAD_BEEF});
    end
    @(negedge CLK);
    m_ren = '0;
    #1;
    total++;
    if ({grant_valid, m_busy} !== {1'b0, 4'hF}) begin
      bad++; $display("FAIL read_back_idle got=%h exp=%h", {grant_valid, m_busy}, {1'b0, 4'hF});
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] eid;
    logic [3:0] ebusy;
    do_reset();
    m_ren = '1;
    s_rdata = 32'h0000_1111;
    for (int k = 0; k < 10; k++) begin
      #1;
      total++;
      if (k % 2 == 0) begin
        if (grant_valid !== 1'b0) begin
          bad++; $display("FAIL rr_idle_k%0d got=%b exp=0", k, grant_valid);
        end
      end else begin
        eid = 2'(((k - 1) / 2) % NM);
        ebusy = ~(4'b0001 << eid);
        if ({grant_valid, grant_id, m_busy} !== {1'b1, eid, ebusy}) begin
          bad++;
          $display("FAIL rr_grant_k%0d got=%h exp=%h", k, {grant_valid, grant_id, m_busy}, {1'b1, eid, ebusy});
        end
      end
      @(negedge CLK);
    end
    m_ren = '0;
    @(negedge CLK);
  endtask

  task automatic test_no_preempt;
    do_reset();
    m_ren = 4'b0001;
    m_addr[0 +: AW] = 32'h0000_1000;
    s_busy = 1'b1;
    @(negedge CLK);
    m_wen = 4'b0010;
    m_addr[AW +: AW] = 32'h2000_0040;
    m_wdata[DW +: DW] = 32'h1234_5678;
    m_byte_en[BW +: BW] = 4'b0011;
    for (int c = 1; c <= 2; c++) begin
      #1;
      total++;
      if ({grant_id, s_ren, s_wen, s_addr, m_busy} !== {2'd0, 1'b1, 1'b0, 32'h0000_1000, 4'hF}) begin
        bad++;
        $display("FAIL np_hold_c%0d got=%h exp=%h", c, {grant_id, s_ren, s_wen, s_addr, m_busy},
                 {2'd0, 1'b1, 1'b0, 32'h0000_1000, 4'hF});
      end
      @(negedge CLK);
    end
    s_busy = 1'b0;
    #1;
    total++;
    if (m_busy !== 4'hE) begin
      bad++; $display("FAIL np_m0_done got=%h exp=%h", m_busy, 4'hE);
    end
    @(negedge CLK);
    m_ren = '0;
    #1;
    total++;
    if (grant_valid !== 1'b0) begin
      bad++; $display("FAIL np_gap got=%b exp=0", grant_valid);
    end
    @(negedge CLK); #1;
    total++;
    if ({grant_valid, grant_id, s_ren, s_wen, s_addr, s_wdata, s_byte_en, m_busy} !==
        {1'b1, 2'd1, 1'b0, 1'b1, 32'h2000_0040, 32'h1234_5678, 4'b0011, 4'hD}) begin
      bad++;
      $display("FAIL np_m1_write got=%h exp=%h", {grant_valid, grant_id, s_ren, s_wen, s_addr, s_wdata, s_byte_en, m_busy},
               {1'b1, 2'd1, 1'b0, 1'b1, 32'h2000_0040, 32'h1234_5678, 4'b0011, 4'hD});
    end
    @(negedge CLK);
    m_wen = '0;
    @(negedge CLK);
  endtask

  task automatic test_timeout;
    do_reset();
    m_ren = 4'b0100;
    s_busy = 1'b1;
    s_rdata = 32'hCAFE_F00D;
    @(negedge CLK);
`ifdef GENERIC_BUS_ARB_TIMEOUT_EN
    for (int b = 1; b <= TO; b++) begin
      #1;
      total++;
      if (b < TO) begin
        if ({m_busy, m_error, timeout, s_ren} !== {4'hF, 4'h0, 1'b0, 1'b1}) begin
          bad++;
          $display("FAIL to_wait_b%0d got=%h exp=%h", b, {m_busy, m_error, timeout, s_ren}, {4'hF, 4'h0, 1'b0, 1'b1});
        end
      end else begin
        if ({m_busy, m_error, timeout, s_ren, m_rdata} !== {4'hB, 4'h4, 1'b1, 1'b0, 32'h0}) begin
          bad++;
          $display("FAIL to_abort got=%h exp=%h", {m_busy, m_error, timeout, s_ren, m_rdata},
                   {4'hB, 4'h4, 1'b1, 1'b0, 32'h0});
        end
      end
      @(negedge CLK);
    end
    m_ren = '0;
    #1;
    total++;
    if ({grant_valid, timeout} !== {1'b0, 1'b0}) begin
      bad++; $display("FAIL to_after got=%h exp=%h", {grant_valid, timeout}, 2'b00);
    end
`else
    repeat (100) @(negedge CLK);
    #1;
    total++;
    if ({grant_valid, grant_id, timeout, m_busy, s_ren} !== {1'b1, 2'd2, 1'b0, 4'hF, 1'b1}) begin
      bad++;
      $display("FAIL hung_slave got=%h exp=%h", {grant_valid, grant_id, timeout, m_busy, s_ren},
               {1'b1, 2'd2, 1'b0, 4'hF, 1'b1});
    end
    m_ren = '0;
`endif
    @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    do_reset();
    m_ren = 4'b0010;
    s_busy = 1'b1;
    @(negedge CLK); #1;
    total++;
    if ({grant_valid, grant_id, s_ren} !== {1'b1, 2'd1, 1'b1}) begin
      bad++; $display("FAIL rm_grant1 got=%h exp=%h", {grant_valid, grant_id, s_ren}, {1'b1, 2'd1, 1'b1});
    end
    #1;
    nRST = 1'b0;
    #1;
    total++;
    if ({grant_valid, s_ren, m_busy} !== {1'b0, 1'b0, 4'hF}) begin
      bad++; $display("FAIL rm_async_drop got=%h exp=%h", {grant_valid, s_ren, m_busy}, {1'b0, 1'b0, 4'hF});
    end
    @(negedge CLK);
    nRST = 1'b1;
    m_ren = 4'b0011;
    @(negedge CLK); #1;
    total++;
    if ({grant_valid, grant_id} !== {1'b1, 2'd0}) begin
      bad++; $display("FAIL rm_m0_first got=%h exp=%h", {grant_valid, grant_id}, {1'b1, 2'd0});
    end
    m_ren = '0;
    s_busy = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_random;
    logic [69:0] es, gs;
    logic [39:0] em, gm;
    logic [3:0]  est, gst;
    logic [NM-1:0] req;
    bit tmo;
    int r;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NM; i++) begin
        r = $urandom_range(0, 9);
        m_ren[i] = (r >= 4 && r <= 6) || r == 9;
        m_wen[i] = (r >= 7);
        m_addr[i*AW +: AW] = $urandom;
        m_wdata[i*DW +: DW] = $urandom;
        m_byte_en[i*BW +: BW] = 4'($urandom);
      end
      s_busy  = ($urandom_range(0, 2) != 0);
      s_error = 1'($urandom);
      s_rdata = $urandom;
      #1;
      tmo = TO_EN && md_busy && s_busy && (md_cnt == TO - 1);
      es = '0;
      em = {4'hF, 4'h0, 32'h0};
      est = {md_busy, 2'(md_gid), tmo};
      if (md_busy) begin
        es = {m_ren[md_owner] & ~tmo, m_wen[md_owner] & ~tmo, m_addr[md_owner*AW +: AW],
              m_wdata[md_owner*DW +: DW], m_byte_en[md_owner*BW +: BW]};
        em[39:36] = 4'hF & ~(4'(!(s_busy && !tmo)) << md_owner);
        em[35:32] = 4'(s_error || tmo) << md_owner;
        em[31:0]  = tmo ? 32'h0 : s_rdata;
      end
      gs  = {s_ren, s_wen, s_addr, s_wdata, s_byte_en};
      gm  = {m_busy, m_error, m_rdata};
      gst = {grant_valid, grant_id, timeout};
      total++;
      if (gs !== es) begin
        bad++; $display("FAIL rand_slave_cyc%0d got=%h exp=%h", cyc, gs, es);
      end
      total++;
      if (gm !== em) begin
        bad++; $display("FAIL rand_master_cyc%0d got=%h exp=%h", cyc, gm, em);
      end
      total++;
      if (gst !== est) begin
        bad++; $display("FAIL rand_status_cyc%0d got=%h exp=%h", cyc, gst, est);
      end
      req = m_ren | m_wen;
      if (!md_busy) begin
        for (int k = 1; k <= NM; k++) begin
          if (!md_busy && req[(md_last + k) % NM]) begin
            md_owner = (md_last + k) % NM;
            md_gid   = md_owner;
            md_busy  = 1'b1;
            md_cnt   = 0;
          end
        end
      end else if (!s_busy || !req[md_owner] || tmo) begin
        md_last = md_owner;
        md_busy = 1'b0;
      end else begin
        md_cnt++;
      end
      @(negedge CLK);
    end
    zero_inputs();
    @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b0;
    zero_inputs();
    md_busy = 1'b0; md_last = NM - 1; md_gid = 0; md_cnt = 0; md_owner = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_no_preempt();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/generic_bus_arbiter.md
Name: generic_bus_arbiter

Overview:
- N-master to 1-slave arbiter on the generic bus protocol.
- Lets the multi-hart core share one external generic bus port; masters are per-hart I-side and D-side requesters.
- Round-robin, non-preemptive, one transaction in flight. Exports grant status for tracker/statistics binding.
- Generalises the single-requester top-level bus hookup to NUM_MASTERS requesters.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (legal ≥1).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte_en width is DATA_W/8.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with the optional feature).
- GRANT_W, (NUM_MASTERS>1 ? $clog2(NUM_MASTERS) : 1), width of grant_id (derived, not overridden).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- m_ren  in  NUM_MASTERS  per-master read request.
- m_wen  in  NUM_MASTERS  per-master write request.
- m_addr  in  NUM_MASTERS*ADDR_W  packed, master i at [i*ADDR_W +: ADDR_W].
- m_wdata  in  NUM_MASTERS*DATA_W  packed write data.
- m_byte_en  in  NUM_MASTERS*DATA_W/8  packed byte enables.
- m_busy  out  NUM_MASTERS  per-master busy; 0 = transaction complete this cycle.
- m_error  out  NUM_MASTERS  per-master error, valid when m_busy[i]=0.
- m_rdata  out  DATA_W  shared read data; qualified by m_busy[i]=0.
- s_ren, s_wen  out  1 each  slave request.
- s_addr  out  ADDR_W.
- s_wdata  out  DATA_W.
- s_byte_en  out  DATA_W/8.
- s_busy, s_error  in  1 each  slave response.
- s_rdata  in  DATA_W.
- grant_valid  out  1  a transaction is in flight.
- grant_id  out  GRANT_W  index of the granted master.
- timeout  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Request for master i: req[i] = m_ren[i] | m_wen[i]. Masters hold the request until they see m_busy[i]=0.
- FSM has 2 states, IDLE and BUSY.
- Reset values: state=IDLE; last_grant=NUM_MASTERS-1 (so master 0 wins first); grant_id=0; grant_valid=0; s_ren/s_wen/s_addr/s_wdata/s_byte_en=0; m_busy all 1; m_error all 0; m_rdata=0; timeout=0.
- IDLE:
  - All s_* outputs are 0.
  - If any req is set, the winner is the first set bit scanning last_grant+1, last_grant+2, … modulo NUM_MASTERS.
  - On that edge: grant_id <= winner, state <= BUSY.
  - Arbitration latency is 1 cycle.
- BUSY:
  - s_ren, s_wen, s_addr, s_wdata and s_byte_en forward the granted master's inputs combinationally.
  - m_busy[grant_id] = s_busy; m_error[grant_id] = s_error; m_rdata = s_rdata.
  - All other m_busy bits are 1 and all other m_error bits are 0.
- Completion:
  - In BUSY with s_busy=0: last_grant <= grant_id and state <= IDLE.
  - Minimum cost is 2 cycles per transaction. There are no back-to-back grants.
- Non-preemptive: requests from other masters during BUSY are ignored until IDLE.
- Granted master drops its request while in BUSY (flush):
  - s_ren and s_wen follow it to 0.
  - The arbiter goes to IDLE next edge and updates last_grant.
  - m_busy[grant_id] still reflects s_busy for that cycle.
- m_ren and m_wen both set: forwarded unchanged (illegal, no checking).
- Reset asserted mid-transaction: immediately forces reset values. The slave sees requests drop asynchronously.
- NUM_MASTERS=1: grant is always 0; behaviour is otherwise identical.
- grant_valid = (state==BUSY).

Optional Feature:
- Macro: GENERIC_BUS_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle while s_busy=1.
  - When the count reaches TIMEOUT_CYCLES-1 with s_busy still 1: m_busy[grant_id]=0, m_error[grant_id]=1, m_rdata=0, and s_ren/s_wen are forced to 0 that cycle.
  - timeout pulses 1 for that cycle; state <= IDLE and last_grant updates.
- Not defined: no counter; timeout is tied 0; a hung slave stalls forever.

Test Plan:
- Reset → m_busy=all 1, s_ren=s_wen=0, grant_valid=0, timeout=0; first cycle after release with no request stays IDLE.
- Master 0 read of 0x8000_0000, slave holds busy 2 cycles then returns 0xDEADBEEF → s_addr=0x8000_0000 from cycle 1; m_busy[0]=0 with m_rdata=0xDEADBEEF in cycle 3; m_busy[1]=1 throughout.
- NUM_MASTERS=4, all requesting continuously, slave completes in 1 cycle → grant_id sequence 0,1,2,3,0 with an IDLE cycle between grants.
- Master 1 requests while master 0 is in BUSY → no preemption; master 1 granted in the cycle after master 0 completes; master 1 write with wdata 0x12345678 and byte_en 4'b0011 appears on s_*.
- TIMEOUT_EN defined with TIMEOUT_CYCLES=8 and s_busy stuck at 1 → on the 8th BUSY cycle m_busy[g]=0, m_error[g]=1, timeout=1 for one cycle, then IDLE; without the macro, still BUSY after 100 cycles.
- nRST pulsed low mid-BUSY → s_ren drops asynchronously; after release, master 0 wins first even if master 1 was previously granted.
